pwm_multi: RTL and testbench
============================

PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/period/duty bit width.
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent PWM outputs.
REQ-003 SHALL have parameter PRESCALE_W, default 8, prescaler width (used only with PWM_PRESCALER_EN).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset (0 = reset).
REQ-006 SHALL have port enable  input  1  1 = counter runs; 0 = counter held, outputs inactive.
REQ-007 SHALL have port load  input  1  one-cycle strobe capturing period/duty/mode/polarity.
REQ-008 SHALL have port period  input  WIDTH  terminal count; PWM period = period+1 ticks (edge mode).
REQ-009 SHALL have port duty  input  CHANNELS*WIDTH  packed duties, channel i at [i*WIDTH +: WIDTH].
REQ-010 SHALL have port mode  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-011 SHALL have port polarity  input  CHANNELS  per-channel output inversion when 1.
REQ-012 SHALL have port prescale  input  PRESCALE_W  tick divider, present only with PWM_PRESCALER_EN.
REQ-013 SHALL have port pwm_out  output  CHANNELS  registered PWM outputs.
REQ-014 SHALL have port period_end  output  1  one-cycle pulse at each period boundary.
REQ-015 SHALL have port pending  output  1  1 = loaded values not yet applied.

Function
REQ-016 SHALL keep active settings in shadow registers (period, duty, mode, polarity); outputs use shadows only.
REQ-017 load with enable=1 SHALL write inputs to pending registers and set pending; a later load before the boundary SHALL overwrite them.
REQ-018 At a boundary with pending=1 SHALL copy pending to shadows and clear pending in the same cycle.
REQ-019 load coincident with a boundary SHALL apply the new inputs at that boundary directly; pending ends 0.
REQ-020 load with enable=0 SHALL write shadows immediately; pending stays 0.
REQ-021 Edge mode: counter counts 0..period then wraps to 0; boundary = cycle counter==period advances.
REQ-022 Center mode: counter counts up 0..period, then down to 0, repeat; boundary = cycle counter==0 while counting down advances (period 2*period ticks); period=0 SHALL hold counter 0 with boundary every tick.
REQ-023 Raw channel i SHALL be 1 iff counter < duty_shadow[i] (unsigned compare); duty=0 -> constant 0, duty>period -> constant 1 (edge mode).
REQ-024 pwm_out[i] SHALL equal raw XOR polarity_shadow[i], registered: one clk latency from counter value.
REQ-025 period_end SHALL pulse high exactly one cycle, registered alongside pwm_out.
REQ-026 enable=0 SHALL hold counter 0, direction up, prescaler 0, period_end 0, pwm_out = polarity_shadow.
REQ-027 enable 0->1 SHALL start counting from 0 on the next tick; first period full length.
REQ-028 A mode change via load SHALL take effect only at a boundary and restart counter at 0 counting up.

Reset
REQ-029 rst=0 SHALL asynchronously clear counter, direction (up), prescaler, all shadows and pending registers, pending, period_end, pwm_out to 0.
REQ-030 Deassertion SHALL be synchronous-released by the user; first count on the first clk edge with rst=1 and enable=1.
REQ-031 Reset mid-period SHALL discard pending values.

Configuration
REQ-032 Macro PWM_PRESCALER_EN SHALL, when defined, add port prescale and advance the counter one tick every prescale+1 clk cycles (prescale=0 -> every cycle); prescale sampled live.
REQ-033 Without PWM_PRESCALER_EN, SHALL omit prescale and prescaler logic; counter ticks every clk cycle.

Verification
REQ-034 WIDTH=8, edge, period=9, duty0=3, pol=0 -> pwm_out[0] high 3 of every 10 cycles, period_end every 10 cycles.
REQ-035 Center, period=4, duty0=2 -> pwm_out[0] pattern 1,1,0,0,0,0,0,1 repeating (8 ticks), symmetric about counter=4.
REQ-036 Running duty0=3, load duty0=7 mid-period -> pending=1 until boundary, old duty completes, next period high 7 cycles.
REQ-037 duty0=0 and duty1=255 with period=9, pol=4'b0011 -> pwm_out[0] constant 1, pwm_out[1] constant 0.
REQ-038 rst=0 pulse mid-period between clk edges -> pwm_out, pending, period_end 0 immediately, restart from counter 0.
REQ-039 With PWM_PRESCALER_EN, prescale=3, period=9, duty0=5 -> period 40 cycles, high 20 cycles.

Source files
------------

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with shadowed settings, edge/center-aligned counting and boundary-synchronous updates.
// Optional feature macro: PWM_PRESCALER_EN adds the prescale port and a tick divider in front of the counter.
module pwm_multi #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       polarity,
`ifdef PWM_PRESCALER_EN
    input  logic [PRESCALE_W-1:0]     prescale,
`endif
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_end,
    output logic                      pending
);

    logic [WIDTH-1:0]          r_cnt;
    logic                      r_dirDown;
    logic [WIDTH-1:0]          r_shPeriod;
    logic [CHANNELS*WIDTH-1:0] r_shDuty;
    logic                      r_shMode;
    logic [CHANNELS-1:0]       r_shPol;
    logic [WIDTH-1:0]          r_pdPeriod;
    logic [CHANNELS*WIDTH-1:0] r_pdDuty;
    logic                      r_pdMode;
    logic [CHANNELS-1:0]       r_pdPol;
    logic                      r_pending;
    logic [CHANNELS-1:0]       r_pwm;
    logic                      r_periodEnd;

    logic                      w_tick;
    logic                      w_atEnd;
    logic                      w_boundary;
    logic                      w_nextMode;
    logic [WIDTH-1:0]          w_nextPeriod;
    logic [WIDTH-1:0]          w_cntNext;
    logic                      w_dirNext;
    logic [CHANNELS-1:0]       w_raw;

`ifdef PWM_PRESCALER_EN
    logic [PRESCALE_W-1:0]     r_prescaleCnt;

    // >= keeps the divider from overrunning when prescale is lowered live
    assign w_tick = (r_prescaleCnt >= prescale);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prescaleCnt <= '0;
        end else if (!enable || w_tick) begin
            r_prescaleCnt <= '0;
        end else begin
            r_prescaleCnt <= r_prescaleCnt + 1'b1;
        end
    end
`else
    // Without the divider every cycle is a tick; the width check only ties off the parameter.
    assign w_tick = (PRESCALE_W >= 1);
`endif

    assign w_atEnd    = r_shMode ? ((r_shPeriod == '0) || (r_dirDown && (r_cnt == '0)))
                                 : (r_cnt == r_shPeriod);
    assign w_boundary = w_tick && w_atEnd;

    // Settings that will be active after the boundary: a coincident load wins over pending values.
    always_comb begin
        w_nextMode   = r_shMode;
        w_nextPeriod = r_shPeriod;
        if (load) begin
            w_nextMode   = mode;
            w_nextPeriod = period;
        end else if (r_pending) begin
            w_nextMode   = r_pdMode;
            w_nextPeriod = r_pdPeriod;
        end
    end

    always_comb begin
        w_cntNext = r_cnt;
        w_dirNext = r_dirDown;
        if (!enable) begin
            w_cntNext = '0;
            w_dirNext = 1'b0;
        end else if (w_boundary) begin
            w_dirNext = 1'b0;
            // Center mode resumes at 1 because the boundary tick already sat at 0.
            if ((w_nextMode != r_shMode) || !w_nextMode || (w_nextPeriod == '0)) begin
                w_cntNext = '0;
            end else begin
                w_cntNext = {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else if (w_tick) begin
            if (!r_shMode) begin
                w_cntNext = r_cnt + 1'b1;
            end else if (!r_dirDown) begin
                if (r_cnt == r_shPeriod) begin
                    w_cntNext = r_cnt - 1'b1;
                    w_dirNext = 1'b1;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end else begin
                w_cntNext = r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_dirDown <= 1'b0;
        end else begin
            r_cnt     <= w_cntNext;
            r_dirDown <= w_dirNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shPeriod <= '0;
            r_shDuty   <= '0;
            r_shMode   <= 1'b0;
            r_shPol    <= '0;
            r_pdPeriod <= '0;
            r_pdDuty   <= '0;
            r_pdMode   <= 1'b0;
            r_pdPol    <= '0;
            r_pending  <= 1'b0;
        end else if (!enable) begin
            if (load) begin
                r_shPeriod <= period;
                r_shDuty   <= duty;
                r_shMode   <= mode;
                r_shPol    <= polarity;
                r_pending  <= 1'b0;
            end
        end else if (w_boundary) begin
            if (load) begin
                r_shPeriod <= period;
                r_shDuty   <= duty;
                r_shMode   <= mode;
                r_shPol    <= polarity;
            end else if (r_pending) begin
                r_shPeriod <= r_pdPeriod;
                r_shDuty   <= r_pdDuty;
                r_shMode   <= r_pdMode;
                r_shPol    <= r_pdPol;
            end
            r_pending <= 1'b0;
        end else if (load) begin
            r_pdPeriod <= period;
            r_pdDuty   <= duty;
            r_pdMode   <= mode;
            r_pdPol    <= polarity;
            r_pending  <= 1'b1;
        end
    end

    always_comb begin
        w_raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_raw[i] = (r_cnt < r_shDuty[i*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm       <= '0;
            r_periodEnd <= 1'b0;
        end else if (!enable) begin
            r_pwm       <= r_shPol;
            r_periodEnd <= 1'b0;
        end else begin
            r_pwm       <= w_raw ^ r_shPol;
            r_periodEnd <= w_boundary;
        end
    end

    assign pwm_out    = r_pwm;
    assign period_end = r_periodEnd;
    assign pending    = r_pending;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed scoreboard bench for pwm_multi: edge, center, polarity, pending updates, mode change and async reset.
module tb_pwm_multi;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      enable;
    logic                      load;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic                      mode;
    logic [CHANNELS-1:0]       polarity;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_end;
    logic                      pending;
`ifdef PWM_PRESCALER_EN
    logic [7:0]                prescale = '0;
`endif

    typedef struct {
        logic [3:0] pwm;
        logic       pe;
        logic       pend;
    } exp_t;

    exp_t       sbQ[$];
    int         checks = 0;
    int         errors = 0;
    int         modelDuty[4];
    logic [3:0] modelPol;

    pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESCALE_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .period     (period),
        .duty       (duty),
        .mode       (mode),
        .polarity   (polarity),
`ifdef PWM_PRESCALER_EN
        .prescale   (prescale),
`endif
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic setDuties(input int d0, input int d1, input int d2, input int d3);
        duty = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    endtask

    function automatic exp_t mk(input int cnt, input logic pe, input logic pend);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.pwm[i] = (cnt < modelDuty[i]) ^ modelPol[i];
        end
        e.pe   = pe;
        e.pend = pend;
        return e;
    endfunction

    function automatic exp_t mkRaw(input logic [3:0] pwm, input logic pe, input logic pend);
        exp_t e;
        e.pwm  = pwm;
        e.pe   = pe;
        e.pend = pend;
        return e;
    endfunction

    task automatic applyStimulus(input logic doLoad, input exp_t e);
        load = doLoad;
        sbQ.push_back(e);
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        @(negedge clk);
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = sbQ.pop_front();
            checkVal({tag, "_pwm"}, pwm_out, e.pwm);
            checkVal({tag, "_periodEnd"}, {3'b0, period_end}, {3'b0, e.pe});
            checkVal({tag, "_pending"}, {3'b0, pending}, {3'b0, e.pend});
        end
    endtask

    initial begin
        int cnt;
        int m;
        rst = 1'b0; enable = 1'b0; load = 1'b0; mode = 1'b0;
        period = '0; duty = '0; polarity = '0;
        #12;
        checkVal("reset_pwm", pwm_out, 4'b0000);
        checkVal("reset_periodEnd", {3'b0, period_end}, 4'b0000);
        checkVal("reset_pending", {3'b0, pending}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        // Edge mode, period 9; coincident load at k=19, mid-period load at k=33
        period = 9; mode = 1'b0; polarity = 4'b0000; setDuties(3, 4, 0, 200);
        applyStimulus(1'b1, mkRaw(4'b0000, 1'b0, 1'b0));
        checkOutput("disabledLoad");
        enable = 1'b1;
        modelPol = 4'b0000;
        modelDuty = '{3, 4, 0, 200};
        for (int k = 0; k < 50; k++) begin
            modelDuty[0] = (k < 20) ? 3 : ((k < 40) ? 5 : 7);
            cnt = k % 10;
            if (k == 19) setDuties(5, 4, 0, 200);
            if (k == 33) setDuties(7, 4, 0, 200);
            applyStimulus((k == 19) || (k == 33), mk(cnt, cnt == 9, (k >= 33) && (k <= 38)));
            checkOutput("edge");
        end

        // Constant-level duties with inverted polarity on channels 0 and 1
        enable = 1'b0;
        setDuties(0, 255, 3, 3); polarity = 4'b0011;
        applyStimulus(1'b1, mkRaw(4'b0000, 1'b0, 1'b0));
        checkOutput("disable1");
        applyStimulus(1'b0, mkRaw(4'b0011, 1'b0, 1'b0));
        checkOutput("idlePolarity");
        enable = 1'b1;
        modelDuty = '{0, 255, 3, 3};
        modelPol = 4'b0011;
        for (int k = 0; k < 20; k++) begin
            cnt = k % 10;
            applyStimulus(1'b0, mk(cnt, cnt == 9, 1'b0));
            checkOutput("constLevels");
        end

        // Center mode period 4, then a load switching to edge mode at the next boundary
        enable = 1'b0;
        mode = 1'b1; period = 4; setDuties(2, 4, 5, 0); polarity = 4'b0000;
        applyStimulus(1'b1, mkRaw(4'b0011, 1'b0, 1'b0));
        checkOutput("disable2");
        applyStimulus(1'b0, mkRaw(4'b0000, 1'b0, 1'b0));
        checkOutput("idleZero");
        enable = 1'b1;
        modelPol = 4'b0000;
        for (int k = 0; k < 40; k++) begin
            if (k == 19) begin
                mode = 1'b0; period = 9; setDuties(3, 4, 6, 0);
            end
            if (k <= 24) begin
                modelDuty = '{2, 4, 5, 0};
                m = k % 8;
                cnt = (m <= 4) ? m : 8 - m;
                applyStimulus(k == 19, mk(cnt, (m == 0) && (k > 0), (k >= 19) && (k <= 23)));
                checkOutput("center");
            end else begin
                modelDuty = '{3, 4, 6, 0};
                cnt = (k - 25) % 10;
                applyStimulus(1'b0, mk(cnt, cnt == 9, 1'b0));
                checkOutput("modeChange");
            end
        end

        // Pending load then asynchronous reset between clock edges
        setDuties(8, 4, 6, 0);
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        checkVal("preReset_pending", {3'b0, pending}, 4'b0001);
        checkVal("preReset_pwm", pwm_out, 4'b0100);
        #2 rst = 1'b0;
        #1;
        checkVal("asyncReset_pwm", pwm_out, 4'b0000);
        checkVal("asyncReset_pending", {3'b0, pending}, 4'b0000);
        checkVal("asyncReset_periodEnd", {3'b0, period_end}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        // Cleared shadows give period 0, so the first load lands on a boundary
        period = 9; mode = 1'b0; polarity = 4'b0000; setDuties(3, 4, 0, 200);
        modelPol = 4'b0000;
        for (int k = 0; k < 15; k++) begin
            if (k == 0) begin
                modelDuty = '{0, 0, 0, 0};
                applyStimulus(1'b1, mk(0, 1'b1, 1'b0));
            end else begin
                modelDuty = '{3, 4, 0, 200};
                cnt = (k - 1) % 10;
                applyStimulus(1'b0, mk(cnt, cnt == 9, 1'b0));
            end
            checkOutput("afterReset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
